// File: rtl/scoreboard_hazard_unit_if.sv
// ID-stage hazard bundle between the pipeline and the scoreboard hazard unit.
// The pipeline side is the master; the hazard unit is the slave.
interface scoreboard_hazard_unit_if #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MAX_PENDING    = 4,
    parameter int CNT_WIDTH      = 16
);
    localparam int PCW = $clog2(MAX_PENDING + 1);

    logic                      ID_VALID;
    logic [REG_ADDR_WIDTH-1:0] ID_ADDR1;
    logic [REG_ADDR_WIDTH-1:0] ID_ADDR2;
    logic                      ID_OPERAND1_SELECT;
    logic                      ID_OPERAND2_SELECT;
    logic                      ID_REG_WRITE_EN;
    logic [REG_ADDR_WIDTH-1:0] ID_REG_WRITE_ADDR;
    logic                      ID_LONG_LAT;
    logic [REG_ADDR_WIDTH-1:0] EX_REG_WRITE_ADDR;
    logic                      EX_DATA_MEM_READ;
    logic                      COMPLETE_VALID;
    logic [REG_ADDR_WIDTH-1:0] COMPLETE_ADDR;
    logic                      FLUSH;
    logic                      STALL;
    logic [1:0]                HAZ_CAUSE;
    logic [PCW-1:0]            PENDING_COUNT;
    logic                      SB_FULL;
    logic                      SB_ERR;
    logic [CNT_WIDTH-1:0]      STALL_CYCLES;

    modport master (
        output ID_VALID, ID_ADDR1, ID_ADDR2,
        output ID_OPERAND1_SELECT, ID_OPERAND2_SELECT,
        output ID_REG_WRITE_EN, ID_REG_WRITE_ADDR, ID_LONG_LAT,
        output EX_REG_WRITE_ADDR, EX_DATA_MEM_READ,
        output COMPLETE_VALID, COMPLETE_ADDR, FLUSH,
        input  STALL, HAZ_CAUSE, PENDING_COUNT,
        input  SB_FULL, SB_ERR, STALL_CYCLES
    );

    modport slave (
        input  ID_VALID, ID_ADDR1, ID_ADDR2,
        input  ID_OPERAND1_SELECT, ID_OPERAND2_SELECT,
        input  ID_REG_WRITE_EN, ID_REG_WRITE_ADDR, ID_LONG_LAT,
        input  EX_REG_WRITE_ADDR, EX_DATA_MEM_READ,
        input  COMPLETE_VALID, COMPLETE_ADDR, FLUSH,
        output STALL, HAZ_CAUSE, PENDING_COUNT,
        output SB_FULL, SB_ERR, STALL_CYCLES
    );
endinterface

// File: rtl/scoreboard_hazard_unit.sv
// Per-register scoreboard hazard detector for the ID stage: RAW, WAW and
// structural stalls on outstanding long-latency writes, plus load-use check.
module scoreboard_hazard_unit #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MAX_PENDING    = 4,
    parameter int LOAD_MODE      = 0,
    parameter int CNT_WIDTH      = 16
) (
    input logic CLK,
    input logic RESET,
    scoreboard_hazard_unit_if.slave bus
);
    localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;
    localparam int PCW      = $clog2(MAX_PENDING + 1);
    localparam logic [REG_ADDR_WIDTH-1:0] X0 = '0;

    logic [NUM_REGS-1:0]  sb_q, sb_d, eff_sb;
    logic [PCW-1:0]       cnt_q, cnt_d, eff_cnt;
    logic                 err_q, err_d;
    logic [CNT_WIDTH-1:0] cyc_q, cyc_d;

    logic comp_nz, comp_hit, comp_miss;
    logic src1, src2;
    logic raw_sb, raw_ex, raw, waw, strct;
    logic stall, issue, set_en;
    logic [1:0] cause;

    always_comb begin
        comp_nz   = bus.COMPLETE_VALID && (bus.COMPLETE_ADDR != X0);
        comp_hit  = comp_nz && sb_q[bus.COMPLETE_ADDR];
        comp_miss = comp_nz && !sb_q[bus.COMPLETE_ADDR];

        // Completions bypass into this cycle's hazard check
        eff_sb = sb_q;
        if (comp_hit) begin
            eff_sb[bus.COMPLETE_ADDR] = 1'b0;
        end
        eff_cnt = cnt_q - PCW'(comp_hit);

        src1 = bus.ID_VALID && !bus.ID_OPERAND1_SELECT &&
               (bus.ID_ADDR1 != X0);
        src2 = bus.ID_VALID && !bus.ID_OPERAND2_SELECT &&
               (bus.ID_ADDR2 != X0);

        raw_sb = (src1 && eff_sb[bus.ID_ADDR1]) ||
                 (src2 && eff_sb[bus.ID_ADDR2]);

        raw_ex = 1'b0;
        if (LOAD_MODE == 0) begin
            raw_ex = bus.EX_DATA_MEM_READ &&
                     (bus.EX_REG_WRITE_ADDR != X0) &&
                     ((src1 && bus.EX_REG_WRITE_ADDR == bus.ID_ADDR1) ||
                      (src2 && bus.EX_REG_WRITE_ADDR == bus.ID_ADDR2));
        end

        raw   = raw_sb || raw_ex;
        waw   = bus.ID_VALID && bus.ID_REG_WRITE_EN &&
                (bus.ID_REG_WRITE_ADDR != X0) &&
                eff_sb[bus.ID_REG_WRITE_ADDR];
        strct = bus.ID_VALID && bus.ID_LONG_LAT && bus.ID_REG_WRITE_EN &&
                (eff_cnt == PCW'(MAX_PENDING));

        stall = !RESET && !bus.FLUSH && (raw || waw || strct);

        // Hazards may overlap, so this is a priority chain
        cause = 2'b00;
        if (stall) begin
            if (raw) begin
                cause = 2'b01;
            end else if (waw) begin
                cause = 2'b10;
            end else begin
                cause = 2'b11;
            end
        end

        issue  = bus.ID_VALID && !stall && !bus.FLUSH;
        set_en = issue && bus.ID_LONG_LAT && bus.ID_REG_WRITE_EN &&
                 (bus.ID_REG_WRITE_ADDR != X0);

        sb_d = eff_sb;
        if (set_en) begin
            sb_d[bus.ID_REG_WRITE_ADDR] = 1'b1;
        end
        cnt_d = eff_cnt + PCW'(set_en);

        err_d = err_q || comp_miss;

        cyc_d = cyc_q;
        if (stall && (cyc_q != {CNT_WIDTH{1'b1}})) begin
            cyc_d = cyc_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sb_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
            cyc_q <= '0;
        end else begin
            sb_q  <= sb_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
            cyc_q <= cyc_d;
        end
    end

    assign bus.STALL         = stall;
    assign bus.HAZ_CAUSE     = cause;
    assign bus.PENDING_COUNT = cnt_q;
    assign bus.SB_FULL       = (cnt_q == PCW'(MAX_PENDING));
    assign bus.SB_ERR        = err_q;
    assign bus.STALL_CYCLES  = cyc_q;
endmodule

// File: doc/scoreboard_hazard_unit.md
Name: scoreboard_hazard_unit

Overview:
- Parametrised successor to the single-cycle load-use hazard detector in the CPU pipeline's ID stage.
- Tracks outstanding long-latency register writes (variable-latency loads, multi-cycle mul/div) in a per-register scoreboard.
- Raises STALL on RAW, WAW or structural (too many outstanding writes) hazards.
- Keeps the classic EX-stage load-use check as a selectable mode, and adds a saturating stall-cycle performance counter and a sticky protocol-error flag.

Parameters:
REG_ADDR_WIDTH, 5, register address width; NUM_REGS = 2**REG_ADDR_WIDTH
MAX_PENDING, 4, maximum outstanding long-latency writes (1..NUM_REGS-1)
LOAD_MODE, 0, 0 = loads fixed single-cycle (EX compare active); 1 = loads variable-latency (scoreboard only, EX compare disabled)
CNT_WIDTH, 16, stall-cycle counter width

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  asynchronous, active-high reset
ID_VALID  input  1  valid instruction in ID
ID_ADDR1  input  REG_ADDR_WIDTH  rs1 address
ID_ADDR2  input  REG_ADDR_WIDTH  rs2 address
ID_OPERAND1_SELECT  input  1  1 = operand1 is PC (rs1 not read)
ID_OPERAND2_SELECT  input  1  1 = operand2 is immediate (rs2 not read)
ID_REG_WRITE_EN  input  1  ID instruction writes rd
ID_REG_WRITE_ADDR  input  REG_ADDR_WIDTH  rd address
ID_LONG_LAT  input  1  ID instruction is long-latency; its rd is tracked in the scoreboard
EX_REG_WRITE_ADDR  input  REG_ADDR_WIDTH  rd of the instruction in EX
EX_DATA_MEM_READ  input  1  EX instruction is a load
COMPLETE_VALID  input  1  a long-latency write-back completes this cycle
COMPLETE_ADDR  input  REG_ADDR_WIDTH  register being completed
FLUSH  input  1  kill the ID instruction this cycle
STALL  output  1  hold the PC and IF/ID; insert a bubble into EX
HAZ_CAUSE  output  2  00 none, 01 RAW, 10 WAW, 11 structural
PENDING_COUNT  output  $clog2(MAX_PENDING+1)  outstanding long-latency writes
SB_FULL  output  1  PENDING_COUNT == MAX_PENDING
SB_ERR  output  1  sticky flag: completion to a register that is not pending
STALL_CYCLES  output  CNT_WIDTH  saturating count of stalled cycles

Behaviour:
- Reset (asynchronous, immediate):
  - Scoreboard, PENDING_COUNT, SB_ERR and STALL_CYCLES clear to 0.
  - STALL and HAZ_CAUSE are forced to 0 while RESET is high.
- Completion bypass (combinational):
  - eff_sb = sb with bit COMPLETE_ADDR cleared when COMPLETE_VALID=1.
  - eff_count = PENDING_COUNT - 1 if a valid completion hits a set bit, else PENDING_COUNT.
- Register x0 never hazards, is never set in the scoreboard, and completions to x0 are ignored (no SB_ERR).
- Source-read conditions:
  - src1 = ID_VALID & ~ID_OPERAND1_SELECT & ID_ADDR1 != 0.
  - src2 = ID_VALID & ~ID_OPERAND2_SELECT & ID_ADDR2 != 0.
- RAW hazard, evaluated per source:
  - src1 & eff_sb[ID_ADDR1], or src2 & eff_sb[ID_ADDR2].
  - When LOAD_MODE=0, additionally: EX_DATA_MEM_READ & EX_REG_WRITE_ADDR != 0 & (src1 & EX_REG_WRITE_ADDR==ID_ADDR1 | src2 & EX_REG_WRITE_ADDR==ID_ADDR2).
- WAW hazard: ID_VALID & ID_REG_WRITE_EN & ID_REG_WRITE_ADDR != 0 & eff_sb[ID_REG_WRITE_ADDR].
- Structural hazard: ID_VALID & ID_LONG_LAT & ID_REG_WRITE_EN & eff_count == MAX_PENDING.
- STALL is the OR of the three hazards and is forced to 0 when FLUSH=1.
- HAZ_CAUSE reports the highest-priority active hazard, priority RAW > WAW > structural. It is 00 when STALL=0.
- Issue:
  - issue = ID_VALID & ~STALL & ~FLUSH.
  - On issue with ID_LONG_LAT & ID_REG_WRITE_EN & rd != 0: at the clock edge, set sb[rd] and increment the count.
- Simultaneous issue and completion:
  - Both take effect in the same cycle.
  - Same register: the set wins, the bit stays 1, and the count is unchanged net.
- Completion on a clear bit (rd != 0): no scoreboard or count change; SB_ERR is set and holds until RESET.
- FLUSH: the scoreboard is not cleared, because older in-flight writes still complete. Completions are processed normally.
- STALL_CYCLES increments by 1 on each clock edge where STALL=1, and saturates at all-ones.
- Latency:
  - Hazard outputs are combinational (same cycle).
  - Scoreboard, count and flag updates are visible the cycle after the edge.

Test Plan:
- LOAD_MODE=0, EX_DATA_MEM_READ=1, EX_REG_WRITE_ADDR=5'b01011, ID_ADDR1=5'b01011, OP1_SEL=0 -> STALL=1, HAZ_CAUSE=01; same stimulus with OP1_SEL=1 -> STALL=0; same stimulus with LOAD_MODE=1 -> STALL=0.
- Long-latency issue to x7 with ID_LONG_LAT=1, no hazard -> next cycle PENDING_COUNT=1. Then ID_ADDR2=7 with OP2_SEL=0 -> STALL=1 and HAZ_CAUSE=01 for 3 cycles. Then COMPLETE_VALID=1, COMPLETE_ADDR=7 -> STALL=0 in the same cycle; STALL_CYCLES=3 afterwards.
- x9 pending, ID writes rd=9 without reading it -> STALL=1, HAZ_CAUSE=10. With rd=9 read via rs1 as well -> HAZ_CAUSE=01.
- MAX_PENDING=4, issue long-latency writes to x1..x4 -> SB_FULL=1. Fifth long-latency issue to x5 -> STALL=1, HAZ_CAUSE=11. Same cycle as COMPLETE x2 -> no stall, issue accepted, count stays 4.
- x3 pending, ID issues long-latency rd=3 while COMPLETE x3 in the same cycle -> STALL=0, sb[3]=1, count unchanged. Then COMPLETE x6 (not pending) -> SB_ERR=1 and stays 1; COMPLETE x0 -> SB_ERR unaffected.
- RAW hazard active with FLUSH=1 -> STALL=0, no issue, counter not incremented. Assert RESET mid-stall with 2 writes pending -> STALL=0 immediately; count, scoreboard, SB_ERR and STALL_CYCLES read 0.
